// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin binary-index arbiter.
package arb_pkg;

  localparam int unsigned ARB_NUM_REQ = 16;
  localparam int unsigned ARB_BIN_W   = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_find_first.sv
// Combinational circular search: first set request at or after start_i,
// wrapping at NUM_REQ (not at 2**BIN_W).
module rr_find_first
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ,
  parameter int unsigned BIN_W   = ARB_BIN_W
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [BIN_W-1:0]   start_i,
  output logic               found_o,
  output logic [BIN_W-1:0]   idx_o
);

  localparam logic [BIN_W:0] NUM_REQ_EXT = (BIN_W + 1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [BIN_W-1:0]   off;
  logic [BIN_W:0]     sum;

  // Bit j of rot is req_i[(start_i + j) mod NUM_REQ]; the doubled vector supplies the wrap.
  assign rot = NUM_REQ'({req_i, req_i} >> start_i);

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = BIN_W'(i);
      end
    end
  end

  assign found_o = |req_i;
  assign sum     = {1'b0, start_i} + {1'b0, off};
  assign idx_o   = (sum >= NUM_REQ_EXT) ? BIN_W'(sum - NUM_REQ_EXT) : BIN_W'(sum);

endmodule : rr_find_first

// File: rtl/rr_arbiter_bin.sv
// Round-robin arbiter producing a registered binary grant index under a
// valid/ready handshake; back-to-back grants without bubbles.
module rr_arbiter_bin
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ,
  parameter int unsigned BIN_W   = ARB_BIN_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  output logic               gnt_valid_o,
  output logic [BIN_W-1:0]   gnt_idx_o,
  input  logic               gnt_ready_i,
  output logic               busy_o
);

  if ((BIN_W != $clog2(NUM_REQ)) || (NUM_REQ < 2)) begin : g_bad_params
    $error("rr_arbiter_bin: NUM_REQ must be >= 2 and BIN_W must equal clog2(NUM_REQ)");
  end

  localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(NUM_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [BIN_W-1:0] ptr_q, ptr_d;
  logic [BIN_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic [BIN_W-1:0] next_ptr;
  logic [BIN_W-1:0] search_start;
  logic             found;
  logic [BIN_W-1:0] found_idx;

  // While granting, the search already looks past the current winner so a
  // handshake can chain straight into the next grant.
  assign next_ptr     = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + BIN_W'(1);
  assign search_start = (state_q == ARB_GRANT) ? next_ptr : ptr_q;

  rr_find_first #(
    .NUM_REQ (NUM_REQ),
    .BIN_W   (BIN_W)
  ) u_find (
    .req_i   (req_i),
    .start_i (search_start),
    .found_o (found),
    .idx_o   (found_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          gnt_idx_d   = found_idx;
          gnt_valid_d = 1'b1;
          state_d     = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (gnt_ready_i) begin
          ptr_d = next_ptr;
          if (found) begin
            gnt_idx_d = found_idx;
          end else begin
            gnt_valid_d = 1'b0;
            state_d     = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt_valid_o = gnt_valid_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign busy_o      = (state_q == ARB_GRANT);

endmodule : rr_arbiter_bin

// File: tb/tb_rr_arbiter_bin.sv
// Directed and random checks of rr_arbiter_bin (16- and 5-requester builds)
// against a circular-search reference model.
module tb_rr_arbiter_bin;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req_a;
  logic        ready_a;
  logic        valid_a, busy_a;
  logic [3:0]  idx_a;
  logic [4:0]  req_b;
  logic        ready_b;
  logic        valid_b, busy_b;
  logic [2:0]  idx_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one set per instance
  int ma_valid, ma_idx, ma_ptr;
  int mb_valid, mb_idx, mb_ptr;

  always #5 clk = ~clk;

  rr_arbiter_bin #(.NUM_REQ(16), .BIN_W(4)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_a),
    .gnt_valid_o (valid_a),
    .gnt_idx_o   (idx_a),
    .gnt_ready_i (ready_a),
    .busy_o      (busy_a)
  );

  rr_arbiter_bin #(.NUM_REQ(5), .BIN_W(3)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_b),
    .gnt_valid_o (valid_b),
    .gnt_idx_o   (idx_b),
    .gnt_ready_i (ready_b),
    .busy_o      (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requester found walking ptr, ptr+1, ... modulo n; -1 if none.
  function automatic int search(input logic [15:0] req, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic model(input logic [15:0] req, input logic rdy, input int n,
                       inout int v, inout int idx, inout int ptr);
    int s;
    if (reset) begin
      v = 0; idx = 0; ptr = 0;
    end else if (v == 0) begin
      s = search(req, ptr, n);
      if (s >= 0) begin v = 1; idx = s; end
    end else if (rdy) begin
      ptr = (idx + 1) % n;
      s = search(req, ptr, n);
      if (s >= 0) idx = s;
      else v = 0;
    end
  endtask

  // Advance one clock, update the models from the pre-edge inputs, compare after the edge.
  task automatic tick();
    @(posedge clk);
    model(req_a, ready_a, 16, ma_valid, ma_idx, ma_ptr);
    model({11'd0, req_b}, ready_b, 5, mb_valid, mb_idx, mb_ptr);
    #1;
    check("a_valid", 32'(valid_a), 32'(ma_valid));
    check("a_idx",   32'(idx_a),   32'(ma_idx));
    check("a_busy",  32'(busy_a),  32'(ma_valid));
    check("b_valid", 32'(valid_b), 32'(mb_valid));
    check("b_idx",   32'(idx_b),   32'(mb_idx));
    check("b_busy",  32'(busy_b),  32'(mb_valid));
    check("b_idx_range", 32'(idx_b < 3'd5), 32'd1);
  endtask

  initial begin
    int exp_a [4];
    int exp_b [4];
    exp_a[0] = 0; exp_a[1] = 5; exp_a[2] = 0; exp_a[3] = 5;
    exp_b[0] = 0; exp_b[1] = 4; exp_b[2] = 0; exp_b[3] = 4;
    ma_valid = 0; ma_idx = 0; ma_ptr = 0;
    mb_valid = 0; mb_idx = 0; mb_ptr = 0;

    reset = 1'b1; req_a = '0; ready_a = 1'b0; req_b = '0; ready_b = 1'b0;
    tick(); tick();
    check("reset_valid", 32'(valid_a), 32'd0);
    check("reset_idx",   32'(idx_a),   32'd0);

    // Idle with no requests
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", 32'(valid_a), 32'd0);
      check("idle_idx",   32'(idx_a),   32'd0);
    end

    // Two requesters, always ready: alternate with no gaps
    req_a = 16'h0021; ready_a = 1'b1;
    req_b = 5'b10001; ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("alt_a_valid", 32'(valid_a), 32'd1);
      check("alt_a_idx",   32'(idx_a),   32'(exp_a[i]));
      check("alt_b_idx",   32'(idx_b),   32'(exp_b[i]));
    end
    req_a = '0; req_b = '0;
    tick();
    check("drain_valid", 32'(valid_a), 32'd0);

    // Top requester, then wrap back to 0
    req_a = 16'h8000;
    tick();
    check("wrap_idx15", 32'(idx_a), 32'd15);
    req_a = 16'h0003;
    tick();
    check("wrap_idx0", 32'(idx_a), 32'd0);
    req_a = '0;
    tick(); tick();

    // Stall holds the grant while other requests change
    req_a = 16'h0008; ready_a = 1'b0;
    tick();
    check("stall_first", 32'(idx_a), 32'd3);
    req_a = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_hold_idx",   32'(idx_a),   32'd3);
      check("stall_hold_valid", 32'(valid_a), 32'd1);
    end
    ready_a = 1'b1;
    tick();
    check("stall_release", 32'(idx_a), 32'd4);

    // Reset during a held grant
    req_a = '0;
    tick();
    req_a = 16'h0080; ready_a = 1'b0;
    tick(); tick();
    check("held7", 32'(idx_a), 32'd7);
    reset = 1'b1;
    tick();
    check("midreset_valid", 32'(valid_a), 32'd0);
    reset = 1'b0; req_a = 16'h0081;
    tick();
    check("post_reset_idx", 32'(idx_a), 32'd0);

    // Random traffic with sparse requests and occasional reset
    for (int i = 0; i < 400; i++) begin
      req_a   = 16'($urandom) & 16'($urandom) & 16'($urandom);
      req_b   = 5'($urandom) & 5'($urandom);
      ready_a = ($urandom_range(0, 3) != 0);
      ready_b = ($urandom_range(0, 2) != 0);
      reset   = ($urandom_range(0, 60) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_arbiter_bin

// File: doc/rr_arbiter_bin.md
Name: rr_arbiter_bin

Overview:
- Round-robin arbiter over NUM_REQ request lines.
- Produces a registered binary grant index with a valid/ready handshake.
- Sits directly upstream of the binary-to-one-hot decoder: gnt_idx_o drives the decoder's binary input, and the decoder's one-hot output fans back to the requesters as per-line grants.
- Handshake gives the consumer backpressure; pointer rotation guarantees fairness.

Parameters:
- NUM_REQ, 16, number of request lines; legal range 2..2**BIN_W.
- BIN_W, 4, width of the grant index; must equal clog2(NUM_REQ), checked by an elaboration-time assertion.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  request vector; bit k set means requester k wants a grant.
- gnt_valid_o  output  1  grant index is valid.
- gnt_idx_o  output  BIN_W  binary index of the granted requester.
- gnt_ready_i  input  1  downstream accepts the grant this cycle.
- busy_o  output  1  high while in the GRANT state (equals gnt_valid_o); debug/observe only.

Behaviour:
- Reset: gnt_valid_o=0, gnt_idx_o=0, busy_o=0, priority pointer ptr=0, state=IDLE. Applies on the edge where reset=1, including mid-grant; a held grant is dropped without a handshake.
- Search function: first set bit of req_i scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1. Index arithmetic wraps at NUM_REQ, not 2**BIN_W.
- IDLE:
  - req_i==0: stay in IDLE.
  - Otherwise: on the next edge gnt_idx_o <= search result, gnt_valid_o <= 1, go to GRANT.
  - Latency from request to valid: 1 cycle.
- GRANT:
  - gnt_idx_o and gnt_valid_o hold stable until gnt_valid_o && gnt_ready_i.
  - The grant is sticky: deasserting req_i[gnt_idx_o] does not withdraw it.
  - Changes on other req_i bits are ignored while holding.
- Handshake edge (valid && ready):
  - ptr <= (gnt_idx_o == NUM_REQ-1) ? 0 : gnt_idx_o+1.
  - A new search runs the same cycle, starting from that next pointer value, over req_i.
  - If a request is found: stay in GRANT with the new gnt_idx_o and valid held high. No bubble; throughput is 1 grant/cycle.
  - Otherwise: gnt_valid_o <= 0, go to IDLE.
- A single persistent requester is granted every cycle (the search wraps back to it).
- gnt_ready_i while gnt_valid_o=0 has no effect.
- ptr changes only on a handshake or reset, never on a stall.
- gnt_idx_o is never >= NUM_REQ.

Decomposition:
- Package arb_pkg holds:
  - state enum arb_state_e {ARB_IDLE, ARB_GRANT};
  - default constants ARB_NUM_REQ=16, ARB_BIN_W=4.
- Sub-module rr_find_first (combinational):
  - inputs: req vector, start pointer;
  - outputs: found flag, BIN_W index;
  - implementation: double-width rotate/mask, then a priority encode.
- The top level holds only ptr, the state register, the output registers and the handshake logic.

Test Plan:
- Reset then req_i=0x0000 for 5 cycles -> gnt_valid_o stays 0, gnt_idx_o=0.
- req_i=0x0021, gnt_ready_i=1 constant -> gnt_valid_o rises 1 cycle after the request; gnt_idx_o sequence 0,5,0,5 with no invalid cycles between.
- req_i=0x8000 (NUM_REQ=16) then handshake -> gnt_idx_o=15, ptr wraps to 0; next req_i=0x0003 -> gnt_idx_o=0.
- Stall: grant idx 3 issued, gnt_ready_i=0 for 4 cycles while req_i changes 0x0008->0x0010 -> gnt_idx_o holds 3, valid held; ready=1 -> next gnt_idx_o=4.
- NUM_REQ=5, BIN_W=3, req_i=5'b10001, ready=1 -> idx 0,4,0,4; never 5..7.
- Reset asserted during a held grant (idx 7, ready=0) -> next edge gnt_valid_o=0, ptr=0; after release with req_i=0x0081 -> gnt_idx_o=0 first.
